// File: rtl/nec_div_iter.sv
// Iterative restoring divider for DIV/DIVU: 2n/n -> n-bit quotient and remainder.
// Wide mode uses n = DW; narrow (byte) mode uses n = DW/2. Divide-by-zero and
// unsigned overflow are flagged one enabled cycle after accept. Signed overflow
// is flagged once the magnitude quotient is known.
module nec_div_iter #(
  parameter int DW  = 16,
  parameter int BPC = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ce,
  input  logic            i_start,
  input  logic            i_wide,
  input  logic            i_is_signed,
  input  logic [2*DW-1:0] i_num,
  input  logic [DW-1:0]   i_denom,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_dbz,
  output logic            o_ovf,
  output logic [DW-1:0]   o_quot,
  output logic [DW-1:0]   o_rem
);
  localparam int HW = DW/2;
  localparam int CW = $clog2(DW/BPC + 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ITER, S_FIX} state_t;

  state_t          r_state;
  logic            r_wide, r_sgn, r_nsign, r_dsign;
  logic [2*DW-1:0] r_nmag;   // |num| until CHECK, then {partial rem, shift/quotient}
  logic [DW-1:0]   r_den;
  logic [CW-1:0]   r_cnt;
  logic            r_busy, r_done, r_dbz, r_ovf;
  logic [DW-1:0]   r_quot, r_rem;

  // Operand magnitudes and signs in the accept cycle
  logic            w_nsign, w_dsign;
  logic [2*DW-1:0] w_nneg_w, w_nmag;
  logic [DW-1:0]   w_nneg_n, w_dneg_w, w_dmag;
  logic [HW-1:0]   w_dneg_n;

  assign w_nsign  = i_is_signed & (i_wide ? i_num[2*DW-1] : i_num[DW-1]);
  assign w_dsign  = i_is_signed & (i_wide ? i_denom[DW-1] : i_denom[HW-1]);
  assign w_nneg_w = -i_num;
  assign w_nneg_n = -i_num[DW-1:0];
  assign w_dneg_w = -i_denom;
  assign w_dneg_n = -i_denom[HW-1:0];
  // The most negative value negates onto itself, which is already its unsigned magnitude.
  assign w_nmag = i_wide ? (w_nsign ? w_nneg_w : i_num)
                         : {{DW{1'b0}}, (w_nsign ? w_nneg_n : i_num[DW-1:0])};
  assign w_dmag = i_wide ? (w_dsign ? w_dneg_w : i_denom)
                         : {{HW{1'b0}}, (w_dsign ? w_dneg_n : i_denom[HW-1:0])};

  // Split the dividend into partial remainder and a left-aligned shift register
  logic [DW-1:0] w_hi, w_lo;
  logic          w_ovf_u;
  assign w_hi    = r_wide ? r_nmag[2*DW-1:DW] : {{HW{1'b0}}, r_nmag[DW-1:HW]};
  assign w_lo    = r_wide ? r_nmag[DW-1:0]    : {r_nmag[HW-1:0], {HW{1'b0}}};
  assign w_ovf_u = (w_hi >= r_den);

  // BPC restoring sub-steps per enabled cycle
  logic [DW-1:0] w_pr, w_sh;
  logic [DW:0]   w_shl;
  always_comb begin
    w_pr  = r_nmag[2*DW-1:DW];
    w_sh  = r_nmag[DW-1:0];
    w_shl = '0;
    for (int b = 0; b < BPC; b++) begin
      w_shl = {w_pr, w_sh[DW-1]};
      if (w_shl >= {1'b0, r_den}) begin
        w_pr = w_shl[DW-1:0] - r_den;
        w_sh = {w_sh[DW-2:0], 1'b1};
      end else begin
        w_pr = w_shl[DW-1:0];
        w_sh = {w_sh[DW-2:0], 1'b0};
      end
    end
  end

  // Sign fix-up and signed range check on the finished magnitudes
  logic [DW-1:0] w_qmag, w_rmag, w_lim, w_mask, w_quot, w_rem;
  logic          w_ovf_s;
  assign w_qmag  = r_wide ? r_nmag[DW-1:0] : {{HW{1'b0}}, r_nmag[HW-1:0]};
  assign w_rmag  = r_nmag[2*DW-1:DW];
  assign w_lim   = r_wide ? {1'b0, {(DW-1){1'b1}}} : {{(HW+1){1'b0}}, {(HW-1){1'b1}}};
  assign w_mask  = r_wide ? {DW{1'b1}} : {{HW{1'b0}}, {HW{1'b1}}};
  assign w_ovf_s = r_sgn & (w_qmag > w_lim);
  assign w_quot  = ((r_nsign ^ r_dsign) ? -w_qmag : w_qmag) & w_mask;
  assign w_rem   = (r_nsign ? -w_rmag : w_rmag) & w_mask;

  // Control FSM with registered results; everything advances only on ce
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_wide  <= 1'b0;
      r_sgn   <= 1'b0;
      r_nsign <= 1'b0;
      r_dsign <= 1'b0;
      r_nmag  <= '0;
      r_den   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else if (i_ce) begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_wide  <= i_wide;
          r_sgn   <= i_is_signed;
          r_nsign <= w_nsign;
          r_dsign <= w_dsign;
          r_nmag  <= w_nmag;
          r_den   <= w_dmag;
          r_dbz   <= 1'b0;
          r_ovf   <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (r_den == '0) begin
            r_dbz   <= 1'b1;
            r_ovf   <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_ovf_u) begin
            r_ovf   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_nmag  <= {w_hi, w_lo};
            r_cnt   <= r_wide ? CW'(DW/BPC) : CW'(HW/BPC);
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          r_nmag <= {w_pr, w_sh};
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (w_ovf_s) begin
            r_ovf <= 1'b1;
          end else begin
            r_quot <= w_quot;
            r_rem  <= w_rem;
            r_ovf  <= 1'b0;
            r_dbz  <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_dbz  = r_dbz;
  assign o_ovf  = r_ovf;
  assign o_quot = r_quot;
  assign o_rem  = r_rem;
endmodule

// File: tb/tb_nec_div_iter.sv
// Bench for nec_div_iter: BPC=1 and BPC=2 instances share stimulus and are
// checked against an arithmetic model of truncating 2n/n division.
module tb_nec_div_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0, start = 1'b0, wide = 1'b0, sgn = 1'b0;
  logic [31:0] num = '0;
  logic [15:0] den = '0;
  logic [1:0]        busy, done, dbz, ovf;
  logic [1:0][15:0]  quot, rem;

  int n_chk = 0, n_pass = 0;

  // expected state shared by both instances
  logic        e_dbz, e_ovf, e_early;
  logic [15:0] e_q = '0, e_r = '0;

  always #5 clk = ~clk;

  nec_div_iter #(.DW(16), .BPC(1)) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_start(start), .i_wide(wide),
    .i_is_signed(sgn), .i_num(num), .i_denom(den),
    .o_busy(busy[0]), .o_done(done[0]), .o_dbz(dbz[0]), .o_ovf(ovf[0]),
    .o_quot(quot[0]), .o_rem(rem[0]));

  nec_div_iter #(.DW(16), .BPC(2)) u_d2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_start(start), .i_wide(wide),
    .i_is_signed(sgn), .i_num(num), .i_denom(den),
    .o_busy(busy[1]), .o_done(done[1]), .o_dbz(dbz[1]), .o_ovf(ovf[1]),
    .o_quot(quot[1]), .o_rem(rem[1]));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Plain-arithmetic reference: sign-extend, divide, range-check.
  task automatic model(input bit w, input bit s, input logic [31:0] a, input logic [15:0] b);
    int     n;
    longint nu, du, N, D, q, r, lim;
    n  = w ? 16 : 8;
    nu = w ? longint'(a) : longint'(a[15:0]);
    du = w ? longint'(b) : longint'(b[7:0]);
    N  = (s && nu[2*n-1]) ? nu - (64'sd1 <<< (2*n)) : nu;
    D  = (s && du[n-1])   ? du - (64'sd1 <<< n)     : du;
    e_ovf = 1'b0; e_dbz = 1'b0; e_early = 1'b0;
    if (D == 0) begin
      e_dbz = 1'b1; e_early = 1'b1;
    end else if (((N < 0) ? -N : N) / ((D < 0) ? -D : D) >= (64'sd1 <<< n)) begin
      e_ovf = 1'b1; e_early = 1'b1;
    end else begin
      q   = N / D;
      r   = N - q * D;
      lim = (64'sd1 <<< (n-1)) - 1;
      if (s && (q > lim || q < -lim)) e_ovf = 1'b1;
      else begin
        e_q = 16'(q & ((64'sd1 <<< n) - 1));
        e_r = 16'(r & ((64'sd1 <<< n) - 1));
      end
    end
  endtask

  // One division on both instances; tog=1 toggles ce every cycle after accept.
  task automatic run_op(input bit w, input bit s, input logic [31:0] a,
                        input logic [15:0] b, input bit tog);
    bit got [2];
    int lat [2];
    int exp_lat [2];
    int mx;
    model(w, s, a, b);
    for (int d = 0; d < 2; d++) begin
      exp_lat[d] = e_early ? 1 : ((w ? 16 : 8) / (d + 1) + 2);
      if (tog) exp_lat[d] = 2 * exp_lat[d];
      got[d] = 1'b0; lat[d] = 0;
    end
    @(negedge clk);
    ce = 1'b1; start = 1'b1; wide = w; sgn = s; num = a; den = b;
    @(posedge clk);
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      start = 1'b0; num = $urandom; den = 16'($urandom);
      wide = 1'($urandom); sgn = 1'($urandom);
      ce = tog ? (k % 2 == 0) : 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (got[d] && k == lat[d] + 1)
          chk($sformatf("done_width[%0d]", d), done[d], tog ? 1 : 0);
        if (!got[d] && done[d]) begin
          got[d] = 1'b1; lat[d] = k;
          chk($sformatf("latency[%0d]", d), k, exp_lat[d]);
          chk($sformatf("dbz[%0d]", d), dbz[d], e_dbz);
          chk($sformatf("ovf[%0d]", d), ovf[d], e_ovf);
          chk($sformatf("quot[%0d]", d), quot[d], e_q);
          chk($sformatf("rem[%0d]", d), rem[d], e_r);
          chk($sformatf("busy_end[%0d]", d), busy[d], 0);
        end
      end
      mx = (lat[0] > lat[1]) ? lat[0] : lat[1];
      if (got[0] && got[1] && k >= mx + 1) break;
    end
    for (int d = 0; d < 2; d++)
      if (!got[d]) chk($sformatf("done_timeout[%0d]", d), 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [15:0] b;
    bit w, s;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_busy[%0d]", d), busy[d], 0);
      chk($sformatf("rst_done[%0d]", d), done[d], 0);
      chk($sformatf("rst_flags[%0d]", d), {dbz[d], ovf[d]}, 0);
      chk($sformatf("rst_quot[%0d]", d), quot[d], 0);
      chk($sformatf("rst_rem[%0d]", d), rem[d], 0);
    end
    @(negedge clk); rst_n = 1'b1;

    // directed cases
    run_op(1, 0, 32'h0001_0005, 16'h0003, 0);
    run_op(1, 1, 32'hFFFF_FFF9, 16'h0002, 0);
    run_op(0, 0, 32'h0000_0400, 16'h0004, 0);
    run_op(1, 0, 32'h1234_5678, 16'h0000, 0);
    run_op(0, 1, 32'h0000_FF80, 16'h0001, 0);
    run_op(0, 0, 32'h0000_FF80, 16'h0001, 0);
    run_op(1, 1, 32'hFFFF_8000, 16'h8000, 0);
    run_op(1, 1, 32'hC000_0000, 16'h8000, 0);
    run_op(0, 1, 32'h0000_0080, 16'h0080, 0);
    run_op(1, 0, 32'h1234_5678, 16'h9ABC, 1);
    run_op(1, 0, 32'h1234_5678, 16'h9ABC, 0);

    // async reset in the middle of an iteration
    @(negedge clk);
    ce = 1'b1; start = 1'b1; wide = 1'b1; sgn = 1'b0; num = 32'h0000_0FFF; den = 16'h0007;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk($sformatf("busy_mid[%0d]", d), busy[d], 1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("arst_busy[%0d]", d), busy[d], 0);
      chk($sformatf("arst_done[%0d]", d), done[d], 0);
      chk($sformatf("arst_quot[%0d]", d), quot[d], 0);
      chk($sformatf("arst_rem[%0d]", d), rem[d], 0);
    end
    e_q = '0; e_r = '0;
    @(negedge clk); rst_n = 1'b1;

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom); s = 1'($urandom);
      a = $urandom >> $urandom_range(0, 31);
      if (s && $urandom_range(0, 1) == 1) a = -a;
      b = 16'($urandom >> $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) b = -b;
      if ($urandom_range(0, 9) == 0) b = w ? 16'h0000 : (b & 16'hFF00);
      run_op(w, s, a, b, 1'($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
